// File: rtl/idct16_mac_pkg.sv
// Shared constants, FSM state type and the round/saturate helper for the
// 16-point inverse DCT multiply-accumulate datapath.
package idct16_mac_pkg;

    localparam int N    = 16;
    localparam int CW   = 18;
    localparam int XW   = 15;
    localparam int RW   = 16;
    localparam int FRAC = 14;
    localparam int AW   = 38;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam logic signed [AW-1:0] RND_HALF = 38'sd8192;
    localparam logic signed [AW-1:0] SAT_HI   = 38'sd16383;
    localparam logic signed [AW-1:0] SAT_LO   = -38'sd16384;

    // Round half-up to the sample grid, then clamp into the XW-bit range.
    function automatic logic signed [XW-1:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] shifted;
        logic signed [XW-1:0] res;
        shifted = (acc + RND_HALF) >>> FRAC;
        if (shifted > SAT_HI) begin
            res = SAT_HI[XW-1:0];
        end else if (shifted < SAT_LO) begin
            res = SAT_LO[XW-1:0];
        end else begin
            res = shifted[XW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/idct16_mac_if.sv
// Coefficient-in / sample-out handshake bundle for the inverse DCT block.
interface idct16_mac_if;
    import idct16_mac_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [CW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [XW-1:0] out_data;
    logic                 out_last;
    logic                 done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, done
    );

endinterface

// File: rtl/idct16_mac_cos_rom.sv
// Cosine basis ROM: a_k * cos((2n+1)k*pi/32) in signed Q1.14, folded from a
// 17-entry quarter-wave table of round(2^14*sqrt(1/8)*cos(m*pi/32)).
module idct_cos_rom
    import idct16_mac_pkg::*;
(
    input  logic [3:0]           n,
    input  logic [3:0]           k,
    output logic signed [RW-1:0] coef
);

    logic [8:0]           prod_s;
    logic [5:0]           m_s;
    logic [5:0]           fold_s;
    logic                 neg_s;
    logic signed [RW-1:0] mag_s;

    // Reduce the phase modulo 2*pi and fold it into the first quadrant.
    always_comb begin
        prod_s = {4'd0, n, 1'b1} * {5'd0, k};
        m_s    = prod_s[5:0];
        if (m_s <= 6'd16) begin
            fold_s = m_s;
            neg_s  = 1'b0;
        end else if (m_s <= 6'd32) begin
            fold_s = 6'd32 - m_s;
            neg_s  = 1'b1;
        end else if (m_s <= 6'd48) begin
            fold_s = m_s - 6'd32;
            neg_s  = 1'b1;
        end else begin
            fold_s = 6'd0 - m_s;
            neg_s  = 1'b0;
        end
    end

    // Quarter-wave magnitude table.
    always_comb begin
        case (fold_s[4:0])
            5'd0:    mag_s = 16'sd5793;
            5'd1:    mag_s = 16'sd5765;
            5'd2:    mag_s = 16'sd5681;
            5'd3:    mag_s = 16'sd5543;
            5'd4:    mag_s = 16'sd5352;
            5'd5:    mag_s = 16'sd5109;
            5'd6:    mag_s = 16'sd4816;
            5'd7:    mag_s = 16'sd4478;
            5'd8:    mag_s = 16'sd4096;
            5'd9:    mag_s = 16'sd3675;
            5'd10:   mag_s = 16'sd3218;
            5'd11:   mag_s = 16'sd2731;
            5'd12:   mag_s = 16'sd2217;
            5'd13:   mag_s = 16'sd1682;
            5'd14:   mag_s = 16'sd1130;
            5'd15:   mag_s = 16'sd568;
            default: mag_s = 16'sd0;
        endcase
    end

    // DC column uses the smaller a_0 weight and is constant across n.
    always_comb begin
        if (k == 4'd0) begin
            coef = 16'sd4096;
        end else if (neg_s) begin
            coef = -mag_s;
        end else begin
            coef = mag_s;
        end
    end

endmodule

// File: rtl/idct16_mac.sv
// 16-point inverse DCT-II: loads 16 coefficients, then computes each output
// sample with 16 serial MAC steps against the cosine ROM.
module idct16_mac
    import idct16_mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    idct16_mac_if.slave bus
);

    state_e               state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic [3:0]           n_q, n_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [CW-1:0] coef_q [N];
    logic signed [CW-1:0] coef_d [N];
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q, done_d;
    logic signed [XW-1:0] out_data_q, out_data_d;

    logic signed [RW-1:0]    rom_s;
    logic signed [CW+RW-1:0] prod_s;
    logic signed [AW-1:0]    mac_s;

    idct_cos_rom u_rom (
        .n    (n_q),
        .k    (k_q),
        .coef (rom_s)
    );

    // One multiply-accumulate step for the current (n, k) pair.
    always_comb begin
        prod_s = coef_q[k_q] * rom_s;
        mac_s  = acc_q + {{(AW-CW-RW){prod_s[CW+RW-1]}}, prod_s};
    end

    // Next-state logic for the LOAD/CALC/EMIT sequencer and its outputs.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        acc_d       = acc_q;
        coef_d      = coef_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    coef_d[k_q] = bus.in_data;
                    if (k_q == 4'd15) begin
                        k_d        = 4'd0;
                        in_ready_d = 1'b0;
                        state_d    = CALC;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end else begin
                    k_d = k_q;
                end
            end
            CALC: begin
                acc_d = mac_s;
                if (k_q == 4'd15) begin
                    // Result is captured here so out_data is a plain register in EMIT.
                    k_d         = 4'd0;
                    out_valid_d = 1'b1;
                    out_last_d  = (n_q == 4'd15);
                    out_data_d  = round_sat(mac_s);
                    state_d     = EMIT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    acc_d       = {AW{1'b0}};
                    k_d         = 4'd0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (n_q == 4'd15) begin
                        n_d        = 4'd0;
                        in_ready_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        n_d     = n_q + 4'd1;
                        state_d = CALC;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                state_d     = LOAD;
                k_d         = 4'd0;
                n_d         = 4'd0;
                acc_d       = {AW{1'b0}};
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State, coefficient file and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            k_q         <= 4'd0;
            n_q         <= 4'd0;
            acc_q       <= {AW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= {XW{1'b0}};
            for (int i = 0; i < N; i++) begin
                coef_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            coef_q      <= coef_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_idct16_mac.sv
// Scoreboard bench for idct16_mac: stimulus pushes expected samples, a monitor
// pops and compares on every output handshake and watches timing/done.
module tb_idct16_mac;
    import idct16_mac_pkg::*;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    idct16_mac_if bus ();

    idct16_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rom_m [16][16];
    int   cyc = 0, last_ev = 0, in_hs = 0, out_hs = 0, done_cnt = 0;
    bit   mon_en = 1'b0, rand_ready = 1'b0, ready_val = 1'b1;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int model(input int x[16], input int n);
        longint acc = 0;
        for (int k = 0; k < 16; k++) acc += longint'(x[k]) * longint'(rom_m[n][k]);
        acc = (acc + 64'sd8192) >>> 14;
        if (acc > 16383) acc = 16383;
        if (acc < -16384) acc = -16384;
        return int'(acc);
    endfunction

    task automatic push_const(input int v);
        for (int n = 0; n < 16; n++) sb.push_back('{v, n == 15});
    endtask

    task automatic push_model(input int x[16]);
        for (int n = 0; n < 16; n++) sb.push_back('{model(x, n), n == 15});
    endtask

    task automatic drive_block(input int x[16], input int gap_pct);
        int  k = 0;
        int  guard = 0;
        bit  took;
        while (k < 16 && guard < 1000) begin
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct) ? 1'b1 : 1'b0;
            bus.in_data  = CW'(x[k]);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) k++;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (k < 16) begin
            n_checks++;
            $display("FAIL load_timeout: got %0d words expected 16", k);
        end
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int t = 0;
        while (done_cnt == start && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == start) begin
            n_checks++;
            $display("FAIL block_timeout: got no done after %0d cycles expected done", t);
        end
        @(posedge clk); #1;
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_outs(input int target);
        int t = 0;
        while (out_hs < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (out_hs < target) begin
            n_checks++;
            $display("FAIL out_timeout: got %0d outputs expected %0d", out_hs, target);
        end
    endtask

    // Output-ready driver: held level or random backpressure.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // Monitor: scoreboard pops, latency, stall stability and done pulse.
    initial begin
        bit                   prev_valid = 1'b0, stall_prev = 1'b0, exp_done = 1'b0;
        logic signed [XW-1:0] prev_data = '0;
        exp_t                 e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en || rst) begin
                prev_valid = 1'b0; stall_prev = 1'b0; exp_done = 1'b0; in_hs = 0;
            end else begin
                if (exp_done) begin
                    check("done_pulse", bus.done, 1);
                    check("in_ready_after_block", bus.in_ready, 1);
                    done_cnt++;
                end else if (bus.done) begin
                    check("done_spurious", bus.done, 0);
                end
                exp_done = 1'b0;
                if (bus.out_valid && !prev_valid) check("latency", cyc - last_ev, 17);
                if (stall_prev && bus.out_valid) check("stall_hold", bus.out_data, prev_data);
                if (bus.in_valid && bus.in_ready) begin
                    in_hs++;
                    if (in_hs == 16) begin in_hs = 0; last_ev = cyc; end
                end
                if (bus.out_valid && bus.out_ready) begin
                    out_hs++;
                    last_ev = cyc;
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out: got %0d expected no output", bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        check("sample", bus.out_data, e.data);
                        check("out_last", bus.out_last, e.last);
                        if (bus.out_last) exp_done = 1'b1;
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_valid = bus.out_valid;
            end
        end
    end

    initial begin
        int x[16];
        int base;
        for (int n = 0; n < 16; n++)
            for (int k = 0; k < 16; k++) begin
                real a, v;
                a = (k == 0) ? 0.25 : $sqrt(0.125);
                v = 16384.0 * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 32.0);
                rom_m[n][k] = $rtoi($floor(v + 0.5));
            end

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_data", bus.out_data, 0);
        mon_en = 1'b1;

        // DC-only blocks with hand-computed results.
        x = '{default: 0};
        push_const(0); drive_block(x, 0); wait_done();
        x[0] = 64; push_const(16); drive_block(x, 0);
        bus.in_valid = 1'b1; bus.in_data = 18'sd12345;
        repeat (20) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_done();
        x[0] = 2;       push_const(1);      drive_block(x, 0); wait_done();
        x[0] = -2;      push_const(0);      drive_block(x, 0); wait_done();
        x[0] = 131071;  push_const(16383);  drive_block(x, 0); wait_done();
        x[0] = -131072; push_const(-16384); drive_block(x, 0); wait_done();

        // Backpressure at n=3.
        x = '{1000, -700, 350, 0, -120, 60, 0, 30, -800, 0, 4000, -4096, 0, 5, -5, 77};
        base = out_hs;
        push_model(x); drive_block(x, 0);
        wait_outs(base + 3);
        @(posedge clk); #1 ready_val = 1'b0;
        begin
            int t = 0;
            while (!bus.out_valid && t < 100) begin @(negedge clk); t++; end
        end
        repeat (5) @(posedge clk);
        #1;
        check("stall_n", out_hs - base, 3);
        check("stall_valid", bus.out_valid, 1);
        ready_val = 1'b1;
        wait_done();

        // Abort mid-block with reset, then a fresh DC block.
        x = '{default: 0}; x[0] = 64;
        base = out_hs;
        push_const(16); drive_block(x, 0);
        wait_outs(base + 7);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_done", bus.done, 0);
        push_const(16); drive_block(x, 0); wait_done();

        // Random blocks with input gaps and random backpressure.
        rand_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) x[k] = int'($urandom_range(0, 8191)) - 4096;
            push_model(x); drive_block(x, 30); wait_done();
        end
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
